// File: rtl/demux3_wr_pkg.sv
// Shared select decode and state encodings for the write-side 3-way demux.
// The read-side select logic uses the same encodings so both directions decode identically.
package demux3_wr_pkg;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned IDX_W  = 2;

  localparam logic [SEL_W-1:0] SEL_CH0  = 2'b00;
  localparam logic [SEL_W-1:0] SEL_CH1  = 2'b01;
  localparam logic [SEL_W-1:0] SEL_CH2  = 2'b10;
  localparam logic [SEL_W-1:0] SEL_RSVD = 2'b11;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } state_t;

  typedef logic [NUM_CH-1:0] ch_vec_t;

  // Reserved select folds onto ch0 without raising an error.
  function automatic ch_vec_t sel_decode(input logic [SEL_W-1:0] sel);
    ch_vec_t v;
    case (sel)
      SEL_CH1: v = 3'b010;
      SEL_CH2: v = 3'b100;
      default: v = 3'b001;
    endcase
    return v;
  endfunction

  function automatic logic [IDX_W-1:0] ch_index(input ch_vec_t v);
    logic [IDX_W-1:0] idx;
    if (v[2])      idx = 2'd2;
    else if (v[1]) idx = 2'd1;
    else           idx = 2'd0;
    return idx;
  endfunction

endpackage

// File: rtl/demux3_wr_hold_timer.sv
// Stall timer for a held beat: expire flags the last permitted stalled cycle.
// TIMEOUT of zero disables dropping entirely.
module hold_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expire
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

      logic [TW-1:0] timer;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          timer <= '0;
        end else if (clear) begin
          timer <= '0;
        end else if (run) begin
          timer <= timer + TW'(1);
        end
      end

      assign expire = run && (timer == TW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/demux3_wr.sv
// Registered 1-entry write demux: one input beat is steered to exactly one of three
// valid/ready channels, with a stall timeout that drops a beat nobody takes.
module demux3_wr
  import demux3_wr_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNTW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       ch_valid,
  input  logic [2:0]       ch_ready,
  output logic             err_timeout,
  output logic [IDX_W-1:0] err_ch,
  output logic [CNTW-1:0]  drop_cnt
);

  state_t state;
  logic   fire;
  logic   accept;
  logic   run;
  logic   expire;
  logic   clear;

  // Only the selected channel's ready can complete the transfer.
  assign fire     = |(ch_valid & ch_ready);
  assign in_ready = (state == ST_EMPTY) || fire;
  assign accept   = in_valid && in_ready;
  assign run      = (state == ST_HELD) && !fire;
  assign clear    = accept || expire;

  hold_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_hold_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .run    (run),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_EMPTY;
      ch_valid    <= '0;
      out_data    <= '0;
      err_timeout <= 1'b0;
      err_ch      <= '0;
      drop_cnt    <= '0;
    end else begin
      err_timeout <= 1'b0;
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            ch_valid <= sel_decode(in_sel);
            out_data <= in_data;
            state    <= ST_HELD;
          end
        end
        ST_HELD: begin
          if (fire) begin
            if (accept) begin
              ch_valid <= sel_decode(in_sel);
              out_data <= in_data;
            end else begin
              ch_valid <= '0;
              state    <= ST_EMPTY;
            end
          end else if (expire) begin
            // Timed-out beat is discarded; report which channel never took it.
            ch_valid    <= '0;
            state       <= ST_EMPTY;
            err_timeout <= 1'b1;
            err_ch      <= ch_index(ch_valid);
            if (drop_cnt != '1) begin
              drop_cnt <= drop_cnt + CNTW'(1);
            end
          end
        end
        default: begin
          ch_valid <= '0;
          state    <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule
